// File: rtl/rr_arb.sv
// Round-robin arbiter: picks one of N requestors and holds a registered one-hot grant until it is acknowledged.
// Latency: 1 cycle from request to grant; acked grants are replaced back-to-back with no bubble.
// Backpressure: i_gnt_ack low freezes o_gnt/o_gnt_vld; i_req changes are ignored while a grant is outstanding.
//
// Ports:
//   clk        - clock, all state updates on the rising edge
//   rst        - synchronous active-high reset; drops any outstanding grant
//   i_req      - [N-1:0] request vector, bit i = requestor i wants a grant
//   o_gnt_vld  - a grant is outstanding
//   o_gnt      - [N-1:0] one-hot grant, zero when o_gnt_vld=0
//   o_gnt_idx  - [$clog2(N)-1:0] binary index of o_gnt, 0 when idle
//                (present only when RR_ARB_GNT_IDX_EN is defined)
//   i_gnt_ack  - consumer accepts the outstanding grant; ignored when idle
//
// Optional feature macro: RR_ARB_GNT_IDX_EN adds o_gnt_idx via rr_arb_enc.

`ifdef RR_ARB_GNT_IDX_EN
// One-hot to binary encoder.
// Latency: combinational.
// Backpressure: none.
//
// Ports:
//   i_oh   - [N-1:0] one-hot (or zero) input
//   o_idx  - [$clog2(N)-1:0] index of the set bit, 0 when input is zero
module rr_arb_enc #(
    parameter int N = 4
) (
    input  logic [N-1:0]         i_oh,
    output logic [$clog2(N)-1:0] o_idx
);
    localparam int W = $clog2(N);

    // OR of the indices of all set bits; exact for one-hot input and
    // naturally zero when no bit is set.
    always_comb begin
        o_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (i_oh[i]) begin
                o_idx = o_idx | W'(i);
            end
        end
    end
endmodule
`endif

module rr_arb #(
    parameter int N = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         i_req,
    output logic                 o_gnt_vld,
    output logic [N-1:0]         o_gnt,
`ifdef RR_ARB_GNT_IDX_EN
    output logic [$clog2(N)-1:0] o_gnt_idx,
`endif
    input  logic                 i_gnt_ack
);
    localparam int W = $clog2(N);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

    state_e         state_q, state_d;
    logic [W-1:0]   ptr_q,   ptr_d;
    logic [N-1:0]   gnt_q,   gnt_d;
    // Binary index of the outstanding grant, kept alongside gnt_q so the
    // post-ack priority pointer needs no encoder on the critical path.
    logic [W-1:0]   gidx_q,  gidx_d;

    logic [W-1:0]   nxt_ptr;
    logic [W-1:0]   scan_start;
    logic [N-1:0]   win_oh;
    logic [W-1:0]   win_idx;

    // Priority after an ack: the slot just past the granted index, wrapping.
    assign nxt_ptr = (gidx_q == W'(N - 1)) ? '0 : gidx_q + W'(1);

    // In GRANT the scan only matters on an ack, and then it must already
    // use the rotated priority so a new winner lands without a bubble.
    assign scan_start = (state_q == ST_GRANT) ? nxt_ptr : ptr_q;

    // Rotating priority pick: walk N slots upward from scan_start modulo N
    // and keep the first requesting slot. Output is one-hot or zero.
    always_comb begin
        logic         found;
        logic [W:0]   pos_ext;
        logic [W-1:0] pos;
        win_oh  = '0;
        win_idx = '0;
        found   = 1'b0;
        pos_ext = '0;
        pos     = '0;
        for (int k = 0; k < N; k++) begin
            pos_ext = {1'b0, scan_start} + (W + 1)'(k);
            if (pos_ext >= (W + 1)'(N)) begin
                pos_ext = pos_ext - (W + 1)'(N);
            end
            pos = pos_ext[W-1:0];
            if (!found && i_req[pos]) begin
                found       = 1'b1;
                win_oh[pos] = 1'b1;
                win_idx     = pos;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        gidx_d  = gidx_q;
        case (state_q)
            ST_IDLE: begin
                if (|i_req) begin
                    gnt_d   = win_oh;
                    gidx_d  = win_idx;
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (i_gnt_ack) begin
                    ptr_d = nxt_ptr;
                    if (|i_req) begin
                        gnt_d  = win_oh;
                        gidx_d = win_idx;
                    end else begin
                        gnt_d   = '0;
                        gidx_d  = '0;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                gnt_d   = '0;
                gidx_d  = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            gnt_q   <= '0;
            gidx_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            gidx_q  <= gidx_d;
        end
    end

    assign o_gnt_vld = (state_q == ST_GRANT);
    assign o_gnt     = gnt_q;

`ifdef RR_ARB_GNT_IDX_EN
    rr_arb_enc #(
        .N (N)
    ) u_enc (
        .i_oh  (gnt_q),
        .o_idx (o_gnt_idx)
    );
`endif

    a_vld_matches_gnt: assert property (@(posedge clk) disable iff (rst)
        o_gnt_vld == (|o_gnt));

    a_gnt_onehot0: assert property (@(posedge clk) disable iff (rst)
        $onehot0(o_gnt));

    a_gnt_stable: assert property (@(posedge clk) disable iff (rst)
        (o_gnt_vld && !i_gnt_ack) |=> $stable(o_gnt));

endmodule

// File: tb/tb_rr_arb.sv
// Directed bench for rr_arb (N=4), plus the N=8 index output when RR_ARB_GNT_IDX_EN is defined.
// Inputs change 1 time unit after each rising edge; outputs are checked at the same point.
// Every expected value below is hand-derived from the arbitration rules.
module tb_rr_arb;
    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] i_req;
    logic         i_gnt_ack;
    logic         o_gnt_vld;
    logic [N-1:0] o_gnt;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

`ifdef RR_ARB_GNT_IDX_EN
    logic [1:0]   o_gnt_idx;
    logic         rst8;
    logic [7:0]   req8;
    logic         ack8;
    logic         vld8;
    logic [7:0]   gnt8;
    logic [2:0]   idx8;

    rr_arb #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .i_req     (i_req),
        .o_gnt_vld (o_gnt_vld),
        .o_gnt     (o_gnt),
        .o_gnt_idx (o_gnt_idx),
        .i_gnt_ack (i_gnt_ack)
    );

    rr_arb #(.N(8)) dut8 (
        .clk       (clk),
        .rst       (rst8),
        .i_req     (req8),
        .o_gnt_vld (vld8),
        .o_gnt     (gnt8),
        .o_gnt_idx (idx8),
        .i_gnt_ack (ack8)
    );
`else
    rr_arb #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .i_req     (i_req),
        .o_gnt_vld (o_gnt_vld),
        .o_gnt     (o_gnt),
        .i_gnt_ack (i_gnt_ack)
    );
`endif

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // rst held 2 cycles with all requests up, then first grant goes to index 0.
    task automatic test_reset;
        rst       = 1'b1;
        i_req     = 4'b1111;
        i_gnt_ack = 1'b0;
        for (int c = 0; c < 2; c++) begin
            step();
            vectors++;
            if (o_gnt_vld !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_vld[%0d]: got %b want 0", c, o_gnt_vld);
            end
            vectors++;
            if (o_gnt !== 4'b0000) begin
                miscompares++;
                $display("FAIL reset_gnt[%0d]: got %b want 0000", c, o_gnt);
            end
        end
        rst = 1'b0;
        step();
        vectors++;
        if (o_gnt_vld !== 1'b1 || o_gnt !== 4'b0001) begin
            miscompares++;
            $display("FAIL reset_first_gnt: got vld=%b gnt=%b want vld=1 gnt=0001", o_gnt_vld, o_gnt);
        end
    endtask

    // Grant 0001 outstanding; ack every cycle with all requests up.
    task automatic test_rotation;
        logic [3:0] exp_seq [4];
        exp_seq[0] = 4'b0010;
        exp_seq[1] = 4'b0100;
        exp_seq[2] = 4'b1000;
        exp_seq[3] = 4'b0001;
        i_req     = 4'b1111;
        i_gnt_ack = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            vectors++;
            if (o_gnt_vld !== 1'b1 || o_gnt !== exp_seq[c]) begin
                miscompares++;
                $display("FAIL rotation[%0d]: got vld=%b gnt=%b want vld=1 gnt=%b", c, o_gnt_vld, o_gnt, exp_seq[c]);
            end
        end
        // Ack index 0 with nothing requesting: back to IDLE, ptr=1.
        i_req = 4'b0000;
        step();
        vectors++;
        if (o_gnt_vld !== 1'b0 || o_gnt !== 4'b0000) begin
            miscompares++;
            $display("FAIL rotation_drain: got vld=%b gnt=%b want vld=0 gnt=0000", o_gnt_vld, o_gnt);
        end
    endtask

    // ptr=1. Request index 2 for one cycle, withhold ack for 5 cycles.
    task automatic test_hold_sticky;
        i_gnt_ack = 1'b0;
        i_req     = 4'b0100;
        step();
        vectors++;
        if (o_gnt !== 4'b0100) begin
            miscompares++;
            $display("FAIL hold_grant: got %b want 0100", o_gnt);
        end
        i_req = 4'b0000;
        for (int c = 0; c < 5; c++) begin
            step();
            vectors++;
            if (o_gnt_vld !== 1'b1 || o_gnt !== 4'b0100) begin
                miscompares++;
                $display("FAIL hold_sticky[%0d]: got vld=%b gnt=%b want vld=1 gnt=0100", c, o_gnt_vld, o_gnt);
            end
        end
        i_gnt_ack = 1'b1;
        step();
        vectors++;
        if (o_gnt_vld !== 1'b0 || o_gnt !== 4'b0000) begin
            miscompares++;
            $display("FAIL hold_release: got vld=%b gnt=%b want vld=0 gnt=0000", o_gnt_vld, o_gnt);
        end
        i_gnt_ack = 1'b0;
    endtask

    // ptr=3. Grant index 3, ack with 0101 -> wraps to 0, then skips to 2.
    task automatic test_wrap_skip;
        i_gnt_ack = 1'b0;
        i_req     = 4'b1000;
        step();
        vectors++;
        if (o_gnt !== 4'b1000) begin
            miscompares++;
            $display("FAIL wrap_gnt3: got %b want 1000", o_gnt);
        end
        i_req     = 4'b0101;
        i_gnt_ack = 1'b1;
        step();
        vectors++;
        if (o_gnt_vld !== 1'b1 || o_gnt !== 4'b0001) begin
            miscompares++;
            $display("FAIL wrap_to0: got vld=%b gnt=%b want vld=1 gnt=0001", o_gnt_vld, o_gnt);
        end
        step();
        vectors++;
        if (o_gnt_vld !== 1'b1 || o_gnt !== 4'b0100) begin
            miscompares++;
            $display("FAIL wrap_skip: got vld=%b gnt=%b want vld=1 gnt=0100", o_gnt_vld, o_gnt);
        end
        // Ack index 2 with nothing requesting: IDLE, ptr=3.
        i_req = 4'b0000;
        step();
        vectors++;
        if (o_gnt_vld !== 1'b0) begin
            miscompares++;
            $display("FAIL wrap_drain: got vld=%b want 0", o_gnt_vld);
        end
        i_gnt_ack = 1'b0;
    endtask

    // ptr=3. Grant index 1, reset while outstanding, ptr returns to 0.
    task automatic test_reset_mid_grant;
        i_gnt_ack = 1'b0;
        i_req     = 4'b0010;
        step();
        vectors++;
        if (o_gnt !== 4'b0010) begin
            miscompares++;
            $display("FAIL midrst_setup: got %b want 0010", o_gnt);
        end
        i_req = 4'b0000;
        rst   = 1'b1;
        step();
        vectors++;
        if (o_gnt_vld !== 1'b0 || o_gnt !== 4'b0000) begin
            miscompares++;
            $display("FAIL midrst_drop: got vld=%b gnt=%b want vld=0 gnt=0000", o_gnt_vld, o_gnt);
        end
        rst   = 1'b0;
        i_req = 4'b1010;
        step();
        vectors++;
        if (o_gnt_vld !== 1'b1 || o_gnt !== 4'b0010) begin
            miscompares++;
            $display("FAIL midrst_regrant: got vld=%b gnt=%b want vld=1 gnt=0010", o_gnt_vld, o_gnt);
        end
    endtask

    // Grant 0010 outstanding; single requestor re-granted on every ack.
    task automatic test_back_to_back;
        i_req     = 4'b0010;
        i_gnt_ack = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            vectors++;
            if (o_gnt_vld !== 1'b1 || o_gnt !== 4'b0010) begin
                miscompares++;
                $display("FAIL b2b_single[%0d]: got vld=%b gnt=%b want vld=1 gnt=0010", c, o_gnt_vld, o_gnt);
            end
        end
        // Last ack of index 1 leaves ptr=2.
        i_req = 4'b0000;
        step();
        vectors++;
        if (o_gnt_vld !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_drain: got vld=%b want 0", o_gnt_vld);
        end
        i_gnt_ack = 1'b0;
    endtask

    // ptr=2; several IDLE cycles (even with ack high) must not move it.
    task automatic test_idle_ptr;
        i_req     = 4'b0000;
        i_gnt_ack = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
        end
        i_gnt_ack = 1'b0;
        i_req     = 4'b1111;
        step();
        vectors++;
        if (o_gnt !== 4'b0100) begin
            miscompares++;
            $display("FAIL idle_ptr_hold: got %b want 0100", o_gnt);
        end
        i_req     = 4'b0000;
        i_gnt_ack = 1'b1;
        step();
        i_gnt_ack = 1'b0;
    endtask

`ifdef RR_ARB_GNT_IDX_EN
    task automatic test_gnt_idx;
        rst8 = 1'b1;
        req8 = 8'h00;
        ack8 = 1'b0;
        step();
        rst8 = 1'b0;
        step();
        vectors++;
        if (vld8 !== 1'b0 || idx8 !== 3'd0) begin
            miscompares++;
            $display("FAIL idx_idle: got vld=%b idx=%0d want vld=0 idx=0", vld8, idx8);
        end
        req8 = 8'b0100_0000;
        step();
        vectors++;
        if (gnt8 !== 8'b0100_0000 || idx8 !== 3'd6) begin
            miscompares++;
            $display("FAIL idx_six: got gnt=%b idx=%0d want gnt=01000000 idx=6", gnt8, idx8);
        end
        req8 = 8'h00;
        ack8 = 1'b1;
        step();
        vectors++;
        if (vld8 !== 1'b0 || idx8 !== 3'd0) begin
            miscompares++;
            $display("FAIL idx_back_idle: got vld=%b idx=%0d want vld=0 idx=0", vld8, idx8);
        end
        ack8 = 1'b0;
        // N=4 instance: grant index 3 from ptr=3 -> idx 3.
        i_req = 4'b1000;
        step();
        vectors++;
        if (o_gnt_idx !== 2'd3) begin
            miscompares++;
            $display("FAIL idx_n4: got %0d want 3", o_gnt_idx);
        end
        i_req     = 4'b0000;
        i_gnt_ack = 1'b1;
        step();
        i_gnt_ack = 1'b0;
    endtask
`endif

    initial begin
        rst       = 1'b1;
        i_req     = '0;
        i_gnt_ack = 1'b0;
`ifdef RR_ARB_GNT_IDX_EN
        rst8 = 1'b1;
        req8 = 8'h00;
        ack8 = 1'b0;
`endif
        test_reset();
        test_rotation();
        test_hold_sticky();
        test_wrap_skip();
        test_reset_mid_grant();
        test_back_to_back();
        test_idle_ptr();
`ifdef RR_ARB_GNT_IDX_EN
        test_gnt_idx();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/rr_arb.md
Name: rr_arb

Overview:
- Registered round-robin arbiter that selects one of N requestors and presents a one-hot grant vector.
- Sits directly upstream of the one-hot-to-binary encoder: o_gnt is exactly the one-hot select that stage consumes to form the winning queue index.
- Grant is held stable until the consumer acknowledges it. Priority then rotates to the requestor after the winner.

Parameters:
- N, 4, number of requestors; legal range 2..64.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous reset, active-high.
- i_req  input  N  request vector; bit i set means requestor i wants a grant.
- o_gnt_vld  output  1  a grant is currently outstanding.
- o_gnt  output  N  one-hot grant vector; all zero when o_gnt_vld=0.
- i_gnt_ack  input  1  consumer accepts the outstanding grant this cycle; ignored when o_gnt_vld=0.

Behaviour:
- Reset (rst=1 at a clock edge): o_gnt_vld=0, o_gnt='0, state=IDLE, priority pointer ptr=0 (index 0 highest priority). rst overrides all other inputs, including a grant outstanding mid-handshake; that grant is dropped with no ack required.
- State storage: state {IDLE, GRANT}, ptr [$clog2(N)-1:0], registered o_gnt.
- Selection function (combinational): winner = first set bit of i_req scanning upward from ptr, wrapping modulo N. Implementation: double-width masked priority pick, or equivalent. Result is strictly one-hot or zero.
- IDLE:
  - if |i_req: register winner into o_gnt, set o_gnt_vld=1, go to GRANT.
  - else remain in IDLE.
  - Latency from request to grant is 1 cycle.
- GRANT with i_gnt_ack=0: o_gnt and o_gnt_vld held unchanged. Grant is sticky even if the granted i_req bit deasserts; i_req changes have no effect.
- GRANT with i_gnt_ack=1:
  - ptr <= (granted index + 1) mod N. When the granted index is N-1, ptr wraps to 0.
  - The next winner is computed in the same cycle using the updated priority, i.e. scanning from granted index+1, with the current i_req.
  - if nonzero: o_gnt <= that winner, stay in GRANT (back-to-back, no bubble cycle).
  - else: o_gnt <= '0, o_gnt_vld <= 0, go to IDLE.
- Fairness: with all N requests continuously asserted and ack every cycle, each requestor is granted exactly once per N grants.
- A single requestor continuously asserting is re-granted on every ack, with no bubble.
- ptr changes only on an ack; it never advances in IDLE.
- Invariants (assertable):
  - o_gnt_vld == |o_gnt
  - $onehot0(o_gnt)
  - o_gnt stable while o_gnt_vld && !i_gnt_ack

Optional Feature:
- Macro: RR_ARB_GNT_IDX_EN.
- Defined: adds output port o_gnt_idx [$clog2(N)-1:0], the binary index of the set bit of o_gnt, produced by instantiating the team's enc block on o_gnt.
  - The index is combinational from the registered o_gnt, so it is valid in the same cycle as o_gnt_vld.
  - o_gnt_idx=0 when o_gnt_vld=0.
- Not defined: port absent, no encoder instantiated; behaviour otherwise identical.

Test Plan:
- Reset: hold rst=1 for 2 cycles with i_req=4'b1111 -> o_gnt_vld=0, o_gnt=4'b0000 throughout. First post-reset edge -> o_gnt=4'b0001.
- Rotation, N=4: i_req=4'b1111 held, i_gnt_ack=1 every cycle -> o_gnt sequence 0001,0010,0100,1000,0001, with no bubble cycles.
- Hold/sticky: i_req=4'b0100 for 1 cycle then 0, ack withheld 5 cycles -> o_gnt=4'b0100 stable for 5 cycles. Ack on cycle 6 -> o_gnt_vld=0 the next cycle.
- Wrap and skip: after a grant of index 3 is acked, i_req=4'b0101 -> next o_gnt=4'b0001 (ptr wrapped to 0). After ack -> o_gnt=4'b0100.
- Reset mid-grant: o_gnt=4'b0010 outstanding, rst=1 one cycle -> o_gnt_vld=0. With i_req=4'b1010 after reset -> o_gnt=4'b0010 (ptr back to 0, so index 1 wins).
- RR_ARB_GNT_IDX_EN defined, N=8: o_gnt=8'b0100_0000 -> o_gnt_idx=6. IDLE -> o_gnt_idx=0.
